// File: rtl/capture_pkg.sv
// capture_pkg: shared state encoding and default trigger latency for the capture controller.
package capture_pkg;
  localparam int TRIG_LAT_DEFAULT = 2;
  typedef enum logic [2:0] {IDLE, LOAD, PRE, WAIT, POST, READY} state_e;
endpackage

// File: rtl/capture_ram.sv
// capture_ram: simple dual-port sample buffer, one write port and one registered read port.
module capture_ram #(
  parameter int WIDTH = 8,
  parameter int AW = 10
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic             re,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);
  logic [WIDTH-1:0] mem [2**AW];
  logic [WIDTH-1:0] rdata_q;
  always_ff @(posedge clock) begin
    if (we) mem[waddr] <= wdata;
  end
  // The read register resets so the readout bus is defined before the first read.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) rdata_q <= '0;
    else if (re) rdata_q <= mem[raddr];
  end
  assign rdata = rdata_q;
endmodule

// File: rtl/capture_controller.sv
// capture_controller: pre/post-trigger capture sequencer with host readout.
// Optional CAPTURE_TIMESTAMP_EN adds trig_time, the sample count from arm to trigger.
module capture_controller
  import capture_pkg::*;
#(
  parameter int SAMPLE_WIDTH = 8,
  parameter int DEPTH_LOG2 = 10,
  parameter int TRIG_LAT = TRIG_LAT_DEFAULT
) (
  input  logic                    clock,
  input  logic                    reset_n,
  input  logic                    start,
  input  logic                    abort,
  input  logic [DEPTH_LOG2-1:0]   pre_count,
  input  logic [DEPTH_LOG2-1:0]   post_count,
  input  logic                    valid,
  input  logic [SAMPLE_WIDTH-1:0] dataIn,
  input  logic                    trig_run,
  output logic                    load_trigs,
  output logic                    arm,
  output logic                    busy,
  output logic                    done,
  input  logic                    rd_en,
  output logic [SAMPLE_WIDTH-1:0] rd_data,
  output logic                    rd_valid,
  output logic                    rd_last
`ifdef CAPTURE_TIMESTAMP_EN
  , output logic [31:0]           trig_time
`endif
);
  localparam int AW = DEPTH_LOG2;
  localparam int CW = DEPTH_LOG2 + 1;
  localparam logic [CW-1:0] DEPTH = CW'(1) << AW;

  state_e state_q, state_d;
  logic [TRIG_LAT-1:0] dv_q, dv_d;
  logic [SAMPLE_WIDTH-1:0] dd_q [TRIG_LAT];
  logic [SAMPLE_WIDTH-1:0] dd_d [TRIG_LAT];
  logic [CW-1:0] pre_q, pre_d, post_q, post_d, cnt_q, cnt_d;
  logic [CW-1:0] pre_in, post_in, post_lim, total;
  logic [AW-1:0] wr_addr_q, wr_addr_d, rd_base_q, rd_base_d;
  logic load_q, load_d, arm_q, arm_d, busy_q, busy_d, done_q, done_d;
  logic rd_valid_q, rd_valid_d, rd_last_q, rd_last_d;
  logic we, rd_accept;

  // Delay the sample stream so the sample that fired the trigger lines up with trig_run.
  always_comb begin
    dv_d = (dv_q << 1) | TRIG_LAT'(valid);
    dd_d[0] = dataIn;
    for (int i = 1; i < TRIG_LAT; i++) dd_d[i] = dd_q[i-1];
  end

  always_comb begin
    pre_in = {1'b0, pre_count};
    post_lim = DEPTH - pre_in;
    post_in = (post_count == '0) ? CW'(1) : {1'b0, post_count};
    post_in = (post_in > post_lim) ? post_lim : post_in;
  end

  assign total = pre_q + post_q;
  assign we = dv_q[TRIG_LAT-1] && (state_q inside {PRE, WAIT, POST});
  assign rd_accept = (state_q == READY) && rd_en && !abort && (cnt_q < total);

  always_comb begin
    state_d = state_q;
    pre_d = pre_q;
    post_d = post_q;
    cnt_d = cnt_q;
    wr_addr_d = wr_addr_q + AW'(we);
    rd_base_d = rd_base_q;
    arm_d = 1'b0;
    rd_valid_d = rd_accept;
    rd_last_d = rd_accept && (cnt_q == total - CW'(1));
    case (state_q)
      IDLE: if (start) begin
        state_d = LOAD;
        pre_d = pre_in;
        post_d = post_in;
      end
      LOAD: begin
        cnt_d = '0;
        wr_addr_d = '0;
        state_d = (pre_q == '0) ? WAIT : PRE;
        arm_d = (pre_q == '0);
      end
      PRE: if (we) begin
        cnt_d = cnt_q + CW'(1);
        state_d = (cnt_d == pre_q) ? WAIT : PRE;
        arm_d = (cnt_d == pre_q);
      end
      WAIT: if (trig_run) begin
        rd_base_d = wr_addr_q - pre_q[AW-1:0];
        state_d = (post_q == CW'(1)) ? READY : POST;
        cnt_d = (post_q == CW'(1)) ? '0 : CW'(1);
      end
      POST: if (we) begin
        state_d = (cnt_q + CW'(1) == post_q) ? READY : POST;
        cnt_d = (cnt_q + CW'(1) == post_q) ? '0 : cnt_q + CW'(1);
      end
      READY: if (rd_accept) begin
        cnt_d = cnt_q + CW'(1);
        state_d = rd_last_d ? IDLE : READY;
      end
      default: state_d = IDLE;
    endcase
    if (abort) begin
      state_d = IDLE;
      arm_d = 1'b0;
    end
    load_d = (state_d == LOAD);
    busy_d = !(state_d inside {IDLE, READY});
    done_d = (state_d == READY);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      dv_q <= '0;
      for (int i = 0; i < TRIG_LAT; i++) dd_q[i] <= '0;
      pre_q <= '0;
      post_q <= '0;
      cnt_q <= '0;
      wr_addr_q <= '0;
      rd_base_q <= '0;
      load_q <= 1'b0;
      arm_q <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      rd_valid_q <= 1'b0;
      rd_last_q <= 1'b0;
    end else begin
      state_q <= state_d;
      dv_q <= dv_d;
      for (int i = 0; i < TRIG_LAT; i++) dd_q[i] <= dd_d[i];
      pre_q <= pre_d;
      post_q <= post_d;
      cnt_q <= cnt_d;
      wr_addr_q <= wr_addr_d;
      rd_base_q <= rd_base_d;
      load_q <= load_d;
      arm_q <= arm_d;
      busy_q <= busy_d;
      done_q <= done_d;
      rd_valid_q <= rd_valid_d;
      rd_last_q <= rd_last_d;
    end
  end

  capture_ram #(.WIDTH(SAMPLE_WIDTH), .AW(AW)) u_ram (
    .clock   (clock),
    .reset_n (reset_n),
    .we      (we),
    .waddr   (wr_addr_q),
    .wdata   (dd_q[TRIG_LAT-1]),
    .re      (rd_accept),
    .raddr   (rd_base_q + cnt_q[AW-1:0]),
    .rdata   (rd_data)
  );

  assign load_trigs = load_q;
  assign arm = arm_q;
  assign busy = busy_q;
  assign done = done_q;
  assign rd_valid = rd_valid_q;
  assign rd_last = rd_last_q;

`ifdef CAPTURE_TIMESTAMP_EN
  logic [31:0] ts_q, ts_d;
  // Counts pre-trigger samples seen while armed; frozen once the trigger is taken.
  always_comb ts_d = (state_q == IDLE && start && !abort) ? '0 :
                     (state_q == WAIT && we && !trig_run && ts_q != '1) ? ts_q + 32'd1 : ts_q;
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) ts_q <= '0;
    else ts_q <= ts_d;
  end
  assign trig_time = ts_q;
`endif
endmodule

// File: doc/capture_controller.md
# capture_controller

Sequencer on the consuming side of the basic trigger: loads trigger masks, pulses `arm`, records pre-trigger samples into a circular buffer, waits for the trigger's `run` indication, records post-trigger samples, then serves the capture to the host through a read handshake. Sits between the sample front-end, `trigger_basic`, and the host readout path.

## Interface

- `SAMPLE_WIDTH`, 8: bits per sample; must match the trigger.
- `DEPTH_LOG2`, 10: buffer depth is 2^DEPTH_LOG2 samples.
- `TRIG_LAT`, 2: cycles from a sample at `dataIn` to the corresponding `trig_run` assertion.

- `clock`  in  1: system clock.
- `reset_n`  in  1: asynchronous, active-low reset.
- `start`  in  1: host pulse; begins a capture from IDLE.
- `abort`  in  1: host pulse; cancels any capture.
- `pre_count`  in  DEPTH_LOG2: samples kept before the trigger; sampled on `start`.
- `post_count`  in  DEPTH_LOG2: samples kept from the trigger onward; sampled on `start`.
- `valid`  in  1: sample strobe.
- `dataIn`  in  SAMPLE_WIDTH: sample bus.
- `trig_run`  in  1: `run` from the trigger.
- `load_trigs`  out  1: one-cycle mask-load strobe to the trigger.
- `arm`  out  1: one-cycle arm strobe to the trigger.
- `busy`  out  1: high in every state except IDLE and READY.
- `done`  out  1: high in READY.
- `rd_en`  in  1: host read request, one sample per cycle.
- `rd_data`  out  SAMPLE_WIDTH: read sample.
- `rd_valid`  out  1: `rd_data` valid.
- `rd_last`  out  1: qualifies the final sample with `rd_valid`.

## Operation

- Sample path: `valid`/`dataIn` are delayed TRIG_LAT cycles internally before being written, so the sample that caused `trig_run` is the first post-trigger sample.
- Length rules, latched on `start`: pre = min(pre_count, DEPTH-1); post = max(post_count, 1), then clamped to DEPTH - pre. Total = pre + post.
- States:
  - IDLE: `start` -> LOAD.
  - LOAD: `load_trigs`=1 for one cycle. Goes to PRE if pre>0; otherwise goes to WAIT and pulses `arm`.
  - PRE: writes delayed valid samples; `trig_run` is ignored. After pre writes, goes to WAIT and pulses `arm` on that transition cycle.
  - WAIT: keeps writing circularly. The first cycle with `trig_run`=1 records trig_addr (the current write address), counts that sample as post #1 and goes to POST, or straight to READY if post==1.
  - POST: writes until post samples have been written, then goes to READY.
  - READY: `done`=1. Readout starts at trig_addr - pre (modulo DEPTH) and returns Total samples oldest first. Goes to IDLE on the cycle `rd_last` is output.
- Writes happen only on delayed-valid cycles; the write address wraps modulo DEPTH.
- `rd_en` outside READY, or after Total reads have been issued, is ignored.
- `abort` from any state -> IDLE on the next edge. `arm`/`load_trigs` go low and `done` is not set.
- Simultaneous `start`+`abort`: abort wins. `start` outside IDLE is ignored.
- Reset mid-operation returns to IDLE. Buffer contents are undefined and not cleared.

## Timing

- Reset values: `load_trigs`, `arm`, `busy`, `done`, `rd_valid` and `rd_last` all 0; `rd_data` 0.
- `start` at cycle N: LOAD at N+1 (`load_trigs`=1), PRE or WAIT at N+2.
- `arm` is registered and high for exactly one cycle per capture.
- Read latency: `rd_en` at cycle N -> `rd_valid`/`rd_data` at N+1 (synchronous RAM). Back-to-back reads are supported.
- All outputs are registered.

## Configuration

- `CAPTURE_TIMESTAMP_EN` defined: adds output `trig_time` [31:0]. It counts delayed-valid samples from the `arm` pulse to the trigger, saturates at 2^32-1, is held through READY, and clears on `start`. Reset value 0.
- Not defined: no counter and no `trig_time` port.

## Structure

- `capture_pkg`: state enum typedef (IDLE, LOAD, PRE, WAIT, POST, READY) and the default TRIG_LAT constant.
- Sub-module `capture_ram`: simple dual-port RAM, one write port and one synchronous read port, 2^DEPTH_LOG2 x SAMPLE_WIDTH.

## Test plan

- DEPTH=16, pre=4, post=4, ramp data 0,1,2..., trigger on value 10 -> readout 6..13, `rd_last` on 13.
- pre=0, post=1 -> `arm` immediately after LOAD; readout is the single trigger sample with `rd_valid` and `rd_last` together.
- pre=15, post=8 at DEPTH=16 -> post clamped to 1; 16 samples read; address wrap exercised.
- `trig_run` pulsed during PRE -> ignored; fresh `arm` pulse on entering WAIT; a later trigger is captured correctly.
- `abort` during WAIT, and `start`+`abort` together in IDLE -> IDLE next cycle, `done`=0, no further `arm`.
- `reset_n` low during POST -> all outputs at reset values; a new `start` completes a normal capture.
